// File: rtl/cv32e40x_xif_offload_tracker.sv
// cv32e40x_xif_offload_tracker: in-order scoreboard of offloaded X-interface instructions
// from issue through commit/kill to result retirement, with a pending-writeback GPR map.
module cv32e40x_xif_offload_tracker #(
  parameter int X_ID_WIDTH = 4,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          issue_valid_i,
  input  logic                          issue_ready_i,
  input  logic                          issue_accept_i,
  input  logic                          issue_writeback_i,
  input  logic [X_ID_WIDTH-1:0]         issue_id_i,
  input  logic [4:0]                    issue_rd_i,
  input  logic                          commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]         commit_id_i,
  input  logic                          commit_kill_i,
  input  logic                          result_valid_i,
  input  logic [X_ID_WIDTH-1:0]         result_id_i,
  output logic                          result_ready_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(DEPTH+1)-1:0]    outstanding_o,
  output logic [31:0]                   rd_busy_o,
  output logic                          protocol_err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic [1:0] {ST_FREE, ST_ISSUED, ST_COMMITTED, ST_KILLED} st_e;
  st_e                   r_st [DEPTH];
  logic [X_ID_WIDTH-1:0] r_id [DEPTH];
  logic [4:0]            r_rd [DEPTH];
  logic                  r_wb [DEPTH];
  logic [PW-1:0]         r_head, r_tail;
  logic [CW-1:0]         r_cnt;
  logic                  r_err;
  logic                  w_cfound, w_alloc_req, w_alloc, w_cmt, w_res_ret, w_retire, w_viol;
  logic [PW-1:0]         w_cidx;
  logic [31:0]           w_busy;
  // Entries outside the head..tail window are FREE, so the first ISSUED hit from head is the oldest.
  always_comb begin
    w_cfound = 1'b0;
    w_cidx   = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      if (!w_cfound && r_st[r_head + PW'(k)] == ST_ISSUED) begin
        w_cfound = 1'b1;
        w_cidx   = r_head + PW'(k);
      end
    end
  end
  always_comb begin
    w_busy = '0;
    for (int k = 0; k < DEPTH; k++)
      if (r_wb[k] && (r_st[k] == ST_ISSUED || r_st[k] == ST_COMMITTED)) w_busy[r_rd[k]] = 1'b1;
    w_busy[0] = 1'b0;
  end
  assign w_alloc_req    = issue_valid_i & issue_ready_i & issue_accept_i;
  assign w_alloc        = w_alloc_req & ~full_o;
  assign w_cmt          = commit_valid_i & w_cfound & (r_id[w_cidx] == commit_id_i);
  assign result_ready_o = r_st[r_head] == ST_COMMITTED;
  assign w_res_ret      = result_valid_i & result_ready_o & (result_id_i == r_id[r_head]);
  assign w_retire       = (r_st[r_head] == ST_KILLED) | w_res_ret;
  // Any result that does not retire is either unready or mismatched; both are violations.
  assign w_viol         = (w_alloc_req & full_o) | (commit_valid_i & ~w_cmt) | (result_valid_i & ~w_res_ret);
  assign full_o         = r_cnt == CW'(DEPTH);
  assign empty_o        = r_cnt == '0;
  assign outstanding_o  = r_cnt;
  assign rd_busy_o      = w_busy;
  assign protocol_err_o = r_err;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_st[k] <= ST_FREE;
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_viol;
      r_cnt <= r_cnt + CW'(w_alloc) - CW'(w_retire);
      if (w_alloc) begin
        r_st[r_tail] <= ST_ISSUED;
        r_id[r_tail] <= issue_id_i;
        r_rd[r_tail] <= issue_rd_i;
        r_wb[r_tail] <= issue_writeback_i;
        r_tail       <= r_tail + 1'b1;
      end
      if (w_cmt) r_st[w_cidx] <= commit_kill_i ? ST_KILLED : ST_COMMITTED;
      if (w_retire) begin
        r_st[r_head] <= ST_FREE;
        r_head       <= r_head + 1'b1;
      end
    end
  end
endmodule
